// File: rtl/mnist_frame_loader_if.sv
// Signal bundle between the host pins, the frame loader and the mnist_top inference core.
`timescale 1ns/1ps
interface mnist_frame_loader_if;
    logic [7:0] host_data;
    logic       host_strobe;
    logic       host_clear;
    logic       host_ready;
    logic [3:0] result;
    logic       result_valid;
    logic       overrun;
    logic       timeout_err;
    logic       core_start;
    logic [7:0] core_pixels;
    logic       core_done;
    logic [3:0] core_prediction;
    logic       core_busy;

    modport master (
        input  host_data, host_strobe, host_clear, core_done, core_prediction, core_busy,
        output host_ready, result, result_valid, overrun, timeout_err, core_start, core_pixels
    );

    modport slave (
        output host_data, host_strobe, host_clear, core_done, core_prediction, core_busy,
        input  host_ready, result, result_valid, overrun, timeout_err, core_start, core_pixels
    );
endinterface

// File: rtl/mnist_frame_loader.sv
// Collects a 16-byte pixel frame from asynchronous host pins, streams it into the
// inference core, latches the predicted digit and guards the core with a watchdog.
`timescale 1ns/1ps
module mnist_frame_loader #(
    parameter int unsigned NUM_BYTES      = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mnist_frame_loader_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_BYTES);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_COLLECT, S_LAUNCH, S_STREAM, S_WAIT} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   strobe_prev_q, strobe_prev_d;
    logic                   strobe_rise_q, strobe_rise_d;
    logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [7:0]             frame_q [NUM_BYTES];
    logic [7:0]             frame_d [NUM_BYTES];
    logic                   host_ready_q, host_ready_d;
    logic [3:0]             result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   core_start_q, core_start_d;
    logic [7:0]             core_pixels_q, core_pixels_d;

    // Strobe synchronizer followed by a registered rising-edge pulse.
    always_comb begin
        sync_d        = SYNC_STAGES'({sync_q, bus.host_strobe});
        strobe_prev_d = sync_q[SYNC_STAGES-1];
        strobe_rise_d = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
    end

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        wd_d           = wd_q;
        frame_d        = frame_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        timeout_err_d  = timeout_err_q;
        core_start_d   = 1'b0;
        core_pixels_d  = 8'h00;

        if (strobe_rise_q && (state_q != S_COLLECT)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_COLLECT: begin
                // A clear in the same cycle as a strobe edge drops that byte.
                if (bus.host_clear) begin
                    wr_idx_d       = '0;
                    overrun_d      = 1'b0;
                    timeout_err_d  = 1'b0;
                    result_valid_d = 1'b0;
                end else if (strobe_rise_q) begin
                    frame_d[wr_idx_q] = bus.host_data;
                    wr_idx_d          = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == '0) begin
                        result_valid_d = 1'b0;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                // Hold off while a core abandoned by the watchdog is still running.
                if (!bus.core_busy) begin
                    core_start_d  = 1'b1;
                    core_pixels_d = frame_q[0];
                    rd_idx_d      = '0;
                    state_d       = S_STREAM;
                end
            end
            S_STREAM: begin
                core_pixels_d = frame_q[rd_idx_q];
                rd_idx_d      = rd_idx_q + IDX_W'(1);
                if (rd_idx_q == LAST_IDX) begin
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (bus.core_done) begin
                    result_d       = bus.core_prediction;
                    result_valid_d = 1'b1;
                    state_d        = S_COLLECT;
                end else if (wd_q == WD_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_COLLECT;
                end
            end
        endcase

        host_ready_d = (state_d == S_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_COLLECT;
            sync_q         <= '0;
            strobe_prev_q  <= 1'b0;
            strobe_rise_q  <= 1'b0;
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            wd_q           <= '0;
            host_ready_q   <= 1'b1;
            result_q       <= 4'h0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            core_start_q   <= 1'b0;
            core_pixels_q  <= 8'h00;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            strobe_prev_q  <= strobe_prev_d;
            strobe_rise_q  <= strobe_rise_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            wd_q           <= wd_d;
            host_ready_q   <= host_ready_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
            core_start_q   <= core_start_d;
            core_pixels_q  <= core_pixels_d;
        end
    end

    // Frame storage carries no reset; contents are only read after a full frame is written.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign bus.host_ready   = host_ready_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.core_start   = core_start_q;
    assign bus.core_pixels  = core_pixels_q;
endmodule

// File: tb/tb_mnist_frame_loader.sv
// Scoreboard bench for mnist_frame_loader: stimulus queues expected pixels/results,
// a negedge monitor pops and compares them as the loader presents them.
`timescale 1ns/1ps
module tb_mnist_frame_loader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mnist_frame_loader_if bus ();

    mnist_frame_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       is_timeout;
        logic [3:0] res;
    } evt_t;

    logic [7:0] exp_pix [$];
    evt_t       exp_evt [$];

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         start_cnt    = 0;
    int         cyc          = 0;
    int         to_cyc       = 0;
    int         st_cyc       = 0;
    int         mon_remain   = 0;
    bit         mon_first    = 1'b0;
    logic       prev_rv      = 1'b0;
    logic       prev_to      = 1'b0;
    int         core_cnt     = 0;
    int         core_lat     = 3763;
    bit         core_never   = 1'b0;
    logic [3:0] core_pred    = 4'd7;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pixel stream after each start pulse, result/timeout events on rising flags.
    initial begin : monitor
        logic [7:0] px;
        evt_t       ev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_remain = 0;
                prev_rv    = 1'b0;
                prev_to    = 1'b0;
            end else begin
                if (mon_remain > 0) begin
                    if (mon_first) begin
                        check("start_width", 32'(bus.core_start), 32'd0);
                        mon_first = 1'b0;
                    end
                    if (exp_pix.size() == 0) begin
                        check("pixel_unexpected", 32'(bus.core_pixels), 32'hFFFF_FFFF);
                    end else begin
                        px = exp_pix.pop_front();
                        check("pixel", 32'(bus.core_pixels), 32'(px));
                    end
                    mon_remain--;
                end
                if (bus.core_start) begin
                    start_cnt++;
                    mon_remain = 16;
                    mon_first  = 1'b1;
                end
                if (bus.result_valid && !prev_rv) begin
                    if (exp_evt.size() == 0) begin
                        check("result_unexpected", 32'(bus.result), 32'hFFFF_FFFF);
                    end else begin
                        ev = exp_evt.pop_front();
                        check("result_kind", 32'(ev.is_timeout), 32'd0);
                        check("result_value", 32'(bus.result), 32'(ev.res));
                    end
                end
                if (bus.timeout_err && !prev_to) begin
                    to_cyc = cyc;
                    if (exp_evt.size() == 0) begin
                        check("timeout_unexpected", 32'(bus.timeout_err), 32'd0);
                    end else begin
                        ev = exp_evt.pop_front();
                        check("timeout_kind", 32'(ev.is_timeout), 32'd1);
                        check("timeout_result_kept", 32'(bus.result), 32'(ev.res));
                    end
                end
                prev_rv = bus.result_valid;
                prev_to = bus.timeout_err;
            end
        end
    end

    // Core model: done pulse core_lat cycles after the start cycle, unless disabled.
    initial begin : core_model
        bus.core_done       = 1'b0;
        bus.core_prediction = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                core_cnt      = 0;
                bus.core_done = 1'b0;
            end else begin
                bus.core_done = 1'b0;
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        bus.core_done       = 1'b1;
                        bus.core_prediction = core_pred;
                    end
                end
                if (bus.core_start && !core_never) core_cnt = core_lat;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.host_data   = b;
        bus.host_strobe = 1'b1;
        repeat (4) @(negedge clk);
        bus.host_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Strobe whose detected edge lands in the same cycle as a one-cycle host_clear.
    task automatic send_byte_clear(input logic [7:0] b);
        bus.host_data   = b;
        bus.host_strobe = 1'b1;
        repeat (3) @(negedge clk);
        bus.host_clear  = 1'b1;
        @(negedge clk);
        bus.host_clear  = 1'b0;
        bus.host_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int i = 0; i < 16; i++) exp_pix.push_back(base + 8'(i));
        for (int i = 0; i < 16; i++) send_byte(base + 8'(i));
    endtask

    // Sends a frame and returns on the negedge where core_start is first visible.
    task automatic send_frame_sync(input logic [7:0] base);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) exp_pix.push_back(base + 8'(i));
        for (int i = 0; i < 15; i++) send_byte(base + 8'(i));
        bus.host_data   = base + 8'd15;
        bus.host_strobe = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.core_start && n < 50);
        check("launch_start", 32'(bus.core_start), 32'd1);
        st_cyc          = cyc;
        bus.host_strobe = 1'b0;
    endtask

    task automatic wait_evt(input int budget);
        int n;
        n = 0;
        while (exp_evt.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("event_within_budget", 32'(exp_evt.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin : stimulus
        int s0;
        rst_n           = 1'b0;
        bus.host_data   = 8'h00;
        bus.host_strobe = 1'b0;
        bus.host_clear  = 1'b0;
        bus.core_busy   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_host_ready", 32'(bus.host_ready), 32'd1);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_core_start", 32'(bus.core_start), 32'd0);
        check("rst_core_pixels", 32'(bus.core_pixels), 32'd0);
        check("rst_flags", 32'({bus.overrun, bus.timeout_err, bus.result}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal frame with a dropped strobe during WAIT.
        core_lat = 3763; core_pred = 4'd7; core_never = 1'b0;
        exp_evt.push_back('{is_timeout: 1'b0, res: 4'd7});
        s0 = start_cnt;
        send_frame_sync(8'h00);
        check("ready_low_in_stream", 32'(bus.host_ready), 32'd0);
        repeat (25) @(negedge clk);
        send_byte(8'hEE);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        wait_evt(5000);
        check("nominal_one_start", 32'(start_cnt - s0), 32'd1);
        check("nominal_result", 32'(bus.result), 32'd7);
        check("nominal_valid", 32'(bus.result_valid), 32'd1);
        check("nominal_ready", 32'(bus.host_ready), 32'd1);

        // Partial frame then clear; next frame must stream without leftovers.
        send_byte(8'h11);
        check("first_byte_clears_valid", 32'(bus.result_valid), 32'd0);
        check("overrun_sticky", 32'(bus.overrun), 32'd1);
        for (int i = 2; i <= 5; i++) send_byte(8'h10 + 8'(i));
        bus.host_clear = 1'b1;
        @(negedge clk);
        bus.host_clear = 1'b0;
        @(negedge clk);
        check("clear_overrun", 32'(bus.overrun), 32'd0);
        core_lat = 100; core_pred = 4'd3;
        exp_evt.push_back('{is_timeout: 1'b0, res: 4'd3});
        send_frame_sync(8'hA0);
        wait_evt(500);

        // Edge coinciding with clear, then done on the watchdog expiry cycle.
        for (int i = 1; i <= 3; i++) send_byte(8'h30 + 8'(i));
        send_byte_clear(8'hCC);
        core_lat = 8207; core_pred = 4'd9;
        exp_evt.push_back('{is_timeout: 1'b0, res: 4'd9});
        send_frame_sync(8'h50);
        wait_evt(9000);
        check("done_wins_valid", 32'(bus.result_valid), 32'd1);
        check("done_wins_no_timeout", 32'(bus.timeout_err), 32'd0);
        check("edge_clear_no_overrun", 32'(bus.overrun), 32'd0);

        // Core never finishes: watchdog expires after 8192 WAIT cycles.
        core_never = 1'b1;
        exp_evt.push_back('{is_timeout: 1'b1, res: 4'd9});
        send_frame_sync(8'h60);
        wait_evt(9000);
        check("timeout_latency", 32'(to_cyc - st_cyc), 32'd8208);
        check("timeout_flag", 32'(bus.timeout_err), 32'd1);
        check("timeout_result_held", 32'(bus.result), 32'd9);
        check("timeout_valid_low", 32'(bus.result_valid), 32'd0);
        check("timeout_ready", 32'(bus.host_ready), 32'd1);

        // Busy core stalls LAUNCH; start fires the cycle after release.
        core_never = 1'b0; core_lat = 50; core_pred = 4'd2;
        bus.core_busy = 1'b1;
        exp_evt.push_back('{is_timeout: 1'b0, res: 4'd2});
        s0 = start_cnt;
        send_frame(8'h70);
        repeat (20) @(negedge clk);
        check("busy_no_start", 32'(start_cnt - s0), 32'd0);
        check("busy_not_ready", 32'(bus.host_ready), 32'd0);
        bus.core_busy = 1'b0;
        @(negedge clk);
        check("start_after_release", 32'(bus.core_start), 32'd1);
        wait_evt(500);
        check("busy_result_valid", 32'(bus.result_valid), 32'd1);
        check("timeout_sticky", 32'(bus.timeout_err), 32'd1);

        // Reset asserted at stream byte 8.
        core_lat = 200; core_pred = 4'd4;
        send_frame_sync(8'h80);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.host_ready), 32'd1);
        check("midrst_pixels", 32'(bus.core_pixels), 32'd0);
        check("midrst_start", 32'(bus.core_start), 32'd0);
        check("midrst_flags", 32'({bus.overrun, bus.timeout_err, bus.result_valid, bus.result}), 32'd0);
        repeat (2) @(negedge clk);
        exp_pix.delete();
        exp_evt.delete();
        rst_n = 1'b1;
        @(negedge clk);
        core_lat = 60; core_pred = 4'd5;
        exp_evt.push_back('{is_timeout: 1'b0, res: 4'd5});
        send_frame_sync(8'h90);
        wait_evt(500);
        check("post_rst_result", 32'(bus.result), 32'd5);

        repeat (5) @(negedge clk);
        check("leftover_pixels", 32'(exp_pix.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : global_guard
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/mnist_frame_loader.md
# mnist_frame_loader

Host-facing front end for `mnist_top`. It collects one 8×8 frame of 2-bit pixels from slow, asynchronous chip pins as 16 strobed bytes and buffers them. It then launches the inference core and streams the frame into it at one byte per clock. It latches the predicted digit for the host and runs a watchdog so a stalled core cannot hang the interface.

## Interface

Parameters:
- `NUM_BYTES`, 16: bytes per frame (4 pixels/byte); fixed by core.
- `SYNC_STAGES`, 2: synchronizer depth on `host_strobe`.
- `TIMEOUT_CYCLES`, 8192: maximum cycles from launch to `core_done` before error.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset is asynchronous and active-low.
- `host_data`, in, 8: pixel byte; [1:0]=px0 … [7:6]=px3, raster order.
- `host_strobe`, in, 1: asynchronous; each rising edge delivers one byte.
- `host_clear`, in, 1: synchronous; discards a partially received frame and clears flags.
- `host_ready`, out, 1: high while bytes are accepted (COLLECT).
- `result`, out, 4: last predicted digit.
- `result_valid`, out, 1: `result` holds a fresh prediction.
- `overrun`, out, 1: sticky; a strobe edge arrived while not ready.
- `timeout_err`, out, 1: sticky; the watchdog expired.
- `core_start`, out, 1: to `mnist_top.start`.
- `core_pixels`, out, 8: to `mnist_top.pixels_in`.
- `core_done`, in, 1: from `mnist_top.done`.
- `core_prediction`, in, 4: from `mnist_top.prediction`.
- `core_busy`, in, 1: from `mnist_top.busy`.

## Operation

- Reset values: all outputs 0 except `host_ready`=1. State=COLLECT, byte count=0. Buffer contents are don't-care.
- Strobe path: `SYNC_STAGES`-flop synchronizer, then one edge-detect flop. An edge is a 0→1 transition of the synchronized signal. `host_data` is sampled on the edge-detect cycle; the host holds it stable from strobe rise for at least `SYNC_STAGES`+2 clocks.
- Buffer: `NUM_BYTES`×8 register array. A 4-bit write index is written in COLLECT only.
- State **COLLECT**:
  - Each edge stores `host_data` at buf[idx] and increments idx.
  - The first accepted byte of a frame clears `result_valid`.
  - When byte 15 is stored, idx wraps to 0 and the state moves to LAUNCH.
  - `host_clear` (when no edge in the same cycle) sets idx=0 and clears `overrun`, `timeout_err` and `result_valid`.
  - An edge and `host_clear` in the same cycle: clear wins and the byte is dropped.
- State **LAUNCH**:
  - Waits while `core_busy`=1; this protects against a core still running after a timeout.
  - When `core_busy`=0: drive `core_start`=1 for exactly one cycle, `core_pixels`=buf[0]. Read idx=0. Go to STREAM.
- State **STREAM**:
  - Sixteen cycles; cycle k (k=0..15) drives `core_pixels`=buf[k]. Exit to WAIT after k=15.
  - `core_start`=0 throughout.
  - Outside STREAM and LAUNCH, `core_pixels`=0.
- State **WAIT**:
  - A 13-bit watchdog, cleared on entry, increments each cycle.
  - On the first cycle `core_done`=1: `result`←`core_prediction`, `result_valid`←1, go to COLLECT.
  - If the watchdog reaches `TIMEOUT_CYCLES`-1 without `core_done`: `timeout_err`←1, `result` unchanged, go to COLLECT.
  - If `core_done` and expiry occur in the same cycle, done wins.
- `core_done` is ignored in every state except WAIT. A late done arriving after a timeout therefore has no effect.
- Any strobe edge outside COLLECT sets `overrun` and the byte is dropped. `host_clear` is ignored outside COLLECT.
- `host_ready` = (state==COLLECT), registered.
- Async reset at any point returns to reset values immediately. The core is reset by the same `rst_n`.

## Timing

- Strobe to store: the byte is stored `SYNC_STAGES`+1 clocks after the first `clk` edge seeing `host_strobe`=1.
- 16th store (cycle S) to launch: `core_start`=1 in cycle S+1 if `core_busy`=0.
- Streaming: `core_pixels`=buf[k] in cycle S+2+k. This matches the core, which samples `start` in IDLE and then captures `pixels_in` on the next 16 edges.
- `result_valid` rises the cycle after `core_done` is first seen. `host_ready` rises in the same cycle.
- End-to-end: about 16 strobes + 1 + 16 + ~3763 core cycles + 1.

## Test plan

- **Nominal frame:** strobe bytes 0x00..0x0F, then a core model asserts done with prediction 7 after 3763 cycles. Require:
  - `core_start` high for exactly 1 cycle.
  - `core_pixels` shows 0x00..0x0F on the 16 following cycles.
  - `result`=7 and `result_valid`=1 one cycle after done.
  - `host_ready` returns to 1.
- **Overrun:** a strobe during STREAM or WAIT requires `overrun`=1 and the byte dropped. A later `host_clear` in COLLECT clears it.
- **Partial clear:** 5 bytes, `host_clear`, then 16 bytes 0xA0..0xAF. Require streamed data 0xA0..0xAF, with no leftover bytes from the first attempt.
- **Timeout:** the core never asserts done. Require:
  - `timeout_err`=1 after 8192 WAIT cycles.
  - Next frame: `core_busy` held at 1 keeps LAUNCH stalled with no `core_start`; release it and start fires in the next cycle.
- **Simultaneous events:** an edge and `host_clear` in the same cycle leave idx=0. `core_done` on the expiry cycle gives `result_valid`=1 and `timeout_err`=0.
- **Reset mid-stream:** assert `rst_n`=0 at STREAM k=8. Require all outputs at reset values immediately and the next full frame to stream correctly.
